timestep_sequencer: RTL

TIMESTEP_SEQUENCER -- requirements
Module: timestep_sequencer

---
 rtl/timestep_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/timestep_sequencer.sv
// timestep_sequencer
// Runs num_steps timesteps. Each timestep drains the spike FIFO, swaps the
// accumulator array, waits for the array to settle, reads back the current of
// every neuron tag, and hands each current to the neuron-update unit with a
// valid/ready handshake.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start, num_steps        begin a run (num_steps sampled on an accepted start)
//   cim_busy, fifo_empty    array / spike FIFO status
//   cim_swap                one-cycle swap request
//   cim_read_en, cim_i_tag  read request and tag; data returns READ_LAT later
//   cim_i_in                current read back from the array
//   cur_valid/tag/value     current presented to the neuron-update unit
//   cur_ready               neuron-update unit accepts the current
//   step_count              completed timesteps in the current run
//   running, done, phase    status: not idle, end-of-run pulse, state code
//
// state    | meaning
// IDLE     | waiting for start
// DRAIN    | waiting for empty spike FIFO and idle array
// SWAP     | one-cycle swap request
// SETTLE   | minimum two cycles, then until array not busy
// RD_ISSUE | read request for the current tag
// RD_WAIT  | waiting out the array read latency
// PRESENT  | current offered to the neuron-update unit
// FINISH   | one-cycle done pulse
module timestep_sequencer #(
  parameter int NUMWIDTH = 16,
  parameter int TAGBITS  = 2,
  parameter int READ_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [15:0]         num_steps,
  input  logic                cim_busy,
  input  logic                fifo_empty,
  output logic                cim_swap,
  output logic                cim_read_en,
  output logic [TAGBITS-1:0]  cim_i_tag,
  input  logic [NUMWIDTH:0]   cim_i_in,
  output logic                cur_valid,
  output logic [TAGBITS-1:0]  cur_tag,
  output logic [NUMWIDTH:0]   cur_value,
  input  logic                cur_ready,
  output logic [15:0]         step_count,
  output logic                running,
  output logic                done,
  output logic [2:0]          phase
);

  localparam int NUMNEURONS = 2 ** TAGBITS;
  localparam logic [TAGBITS-1:0] TAG_LAST = TAGBITS'(NUMNEURONS - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DRAIN    = 3'd1;
  localparam logic [2:0] SWAP     = 3'd2;
  localparam logic [2:0] SETTLE   = 3'd3;
  localparam logic [2:0] RD_ISSUE = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] PRESENT  = 3'd6;
  localparam logic [2:0] FINISH   = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [TAGBITS-1:0]  tag_q, tag_d;
  logic [15:0]         step_count_q, step_count_d;
  logic [15:0]         num_steps_q, num_steps_d;
  logic                settle_q, settle_d;
  logic [7:0]          wait_q, wait_d;
  logic [TAGBITS-1:0]  cur_tag_q, cur_tag_d;
  logic [NUMWIDTH:0]   cur_value_q, cur_value_d;
  logic [15:0]         step_next;

  assign step_next = step_count_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    step_count_d = step_count_q;
    num_steps_d  = num_steps_q;
    settle_d     = settle_q;
    wait_d       = wait_q;
    cur_tag_d    = cur_tag_q;
    cur_value_d  = cur_value_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_steps_d  = num_steps;
          step_count_d = 16'd0;
          state_d      = (num_steps == 16'd0) ? FINISH : DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !cim_busy) state_d = SWAP;
      end
      SWAP: begin
        // settle_q=1 marks the first of the two mandatory settle cycles
        settle_d = 1'b1;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q) begin
          settle_d = 1'b0;
        end else if (!cim_busy) begin
          tag_d   = '0;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        // RD_WAIT lasts READ_LAT cycles so capture lands on the data-valid cycle
        wait_d  = 8'(READ_LAT - 1);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_q == 8'd0) begin
          cur_value_d = cim_i_in;
          cur_tag_d   = tag_q;
          state_d     = PRESENT;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      PRESENT: begin
        if (cur_ready) begin
          if (tag_q != TAG_LAST) begin
            tag_d   = tag_q + 1'b1;
            state_d = RD_ISSUE;
          end else begin
            step_count_d = step_next;
            state_d      = (step_next == num_steps_q) ? FINISH : DRAIN;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      step_count_q <= 16'd0;
      num_steps_q  <= 16'd0;
      settle_q     <= 1'b0;
      wait_q       <= 8'd0;
      cur_tag_q    <= '0;
      cur_value_q  <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      step_count_q <= step_count_d;
      num_steps_q  <= num_steps_d;
      settle_q     <= settle_d;
      wait_q       <= wait_d;
      cur_tag_q    <= cur_tag_d;
      cur_value_q  <= cur_value_d;
    end
  end

  assign cim_swap    = (state_q == SWAP);
  assign cim_read_en = (state_q == RD_ISSUE);
  assign cim_i_tag   = tag_q;
  assign cur_valid   = (state_q == PRESENT);
  assign cur_tag     = cur_tag_q;
  assign cur_value   = cur_value_q;
  assign step_count  = step_count_q;
  assign running     = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign phase       = state_q;

endmodule
